// File: rtl/bp_stream_host_router.sv
// Host-side stream router: address-decoded inbound fan-out to per-channel FIFOs,
// round-robin merge of channel streams into one registered host stream.
module bp_stream_host_router #(
    parameter int          num_chan_p          = 2,
    parameter int          stream_addr_width_p = 32,
    parameter int          stream_data_width_p = 32,
    parameter int unsigned base_addr_p         = 'h10,
    parameter int unsigned addr_stride_p       = 'h10,
    parameter int unsigned status_addr_p       = 'hF0,
    parameter int          fifo_els_p          = 4,
    localparam int         chan_w_lp = (num_chan_p > 1) ? $clog2(num_chan_p) : 1
) (
    input  logic                                     clk_i,
    input  logic                                     reset_n_i,
    input  logic                                     stream_v_i,
    input  logic [stream_addr_width_p-1:0]           stream_addr_i,
    input  logic [stream_data_width_p-1:0]           stream_data_i,
    output logic                                     stream_yumi_o,
    output logic [num_chan_p-1:0]                    chan_v_o,
    output logic [num_chan_p*stream_data_width_p-1:0] chan_data_o,
    input  logic [num_chan_p-1:0]                    chan_yumi_i,
    input  logic [num_chan_p-1:0]                    chan_v_i,
    input  logic [num_chan_p*stream_data_width_p-1:0] chan_data_i,
    output logic [num_chan_p-1:0]                    chan_ready_o,
    output logic                                     stream_v_o,
    output logic [stream_data_width_p-1:0]           stream_data_o,
    output logic [chan_w_lp-1:0]                     stream_chan_o,
    input  logic                                     stream_ready_i,
    output logic [15:0]                              unmapped_cnt_o
);

    localparam int ptr_w_lp = $clog2(fifo_els_p);
    localparam int cnt_w_lp = $clog2(fifo_els_p + 1);
    localparam int dw_lp    = stream_data_width_p;

    function automatic logic status_aliases();
        logic a;
        a = 1'b0;
        for (int k = 0; k < num_chan_p; k++) begin
            if (base_addr_p + k * addr_stride_p == status_addr_p) a = 1'b1;
        end
        return a;
    endfunction

    localparam logic status_alias_lp = status_aliases();

    function automatic logic [ptr_w_lp-1:0] ptr_next(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(fifo_els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [num_chan_p-1:0] hit;
    logic [num_chan_p-1:0] full;
    logic                  status_hit;
    logic                  chan_hit;
    logic                  status_wr;
    logic                  drop;

    for (genvar k = 0; k < num_chan_p; k++) begin : g_hit
        assign hit[k] = (stream_addr_i ==
                         stream_addr_width_p'(base_addr_p + k * addr_stride_p));
    end

    assign status_hit = (stream_addr_i == stream_addr_width_p'(status_addr_p));
    assign chan_hit   = |hit;

    // Blocked only when the addressed FIFO is full; everything else drains at once.
    assign stream_yumi_o = reset_n_i & stream_v_i & ~(|(hit & full));
    assign status_wr     = stream_yumi_o & status_hit;
    assign drop          = stream_yumi_o & ~chan_hit & ~status_hit;

    for (genvar k = 0; k < num_chan_p; k++) begin : g_fifo
        logic [dw_lp-1:0]    mem [fifo_els_p];
        logic [ptr_w_lp-1:0] rd_ptr;
        logic [ptr_w_lp-1:0] wr_ptr;
        logic [cnt_w_lp-1:0] count;
        logic                enq;
        logic                deq;

        assign full[k]                   = (count == cnt_w_lp'(fifo_els_p));
        assign chan_v_o[k]               = (count != '0);
        assign chan_data_o[k*dw_lp +: dw_lp] = mem[rd_ptr];
        assign enq                       = stream_yumi_o & hit[k];
        assign deq                       = chan_yumi_i[k] & chan_v_o[k];

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (enq) wr_ptr <= ptr_next(wr_ptr);
                if (deq) rd_ptr <= ptr_next(rd_ptr);
                if (enq & ~deq) begin
                    count <= count + 1'b1;
                end else if (deq & ~enq) begin
                    count <= count - 1'b1;
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (enq) mem[wr_ptr] <= stream_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            unmapped_cnt_o <= '0;
        end else if (status_wr) begin
            unmapped_cnt_o <= '0;
        end else if (drop && unmapped_cnt_o != 16'hFFFF) begin
            unmapped_cnt_o <= unmapped_cnt_o + 16'd1;
        end
    end

    logic                 free;
    logic                 found;
    logic [chan_w_lp-1:0] gidx;
    logic [chan_w_lp-1:0] rr_q;
    logic [chan_w_lp-1:0] rr_next;
    logic [chan_w_lp:0]   scan;
    logic [dw_lp-1:0]     gdata;

    assign free = reset_n_i & (~stream_v_o | stream_ready_i);

    // Scan channels starting at the rr pointer, wrapping past the last one.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        scan  = '0;
        for (int i = 0; i < num_chan_p; i++) begin
            scan = {1'b0, rr_q} + (chan_w_lp + 1)'(i);
            if (scan >= (chan_w_lp + 1)'(num_chan_p)) begin
                scan = scan - (chan_w_lp + 1)'(num_chan_p);
            end
            if (!found && chan_v_i[scan[chan_w_lp-1:0]]) begin
                found = 1'b1;
                gidx  = scan[chan_w_lp-1:0];
            end
        end
    end

    always_comb begin
        chan_ready_o = '0;
        if (free & found) chan_ready_o[gidx] = 1'b1;
    end

    assign gdata   = chan_data_i[gidx*dw_lp +: dw_lp];
    assign rr_next = (gidx == chan_w_lp'(num_chan_p - 1)) ? '0 : gidx + 1'b1;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stream_v_o    <= 1'b0;
            stream_data_o <= '0;
            stream_chan_o <= '0;
            rr_q          <= '0;
        end else if (free) begin
            if (found) begin
                stream_v_o    <= 1'b1;
                stream_data_o <= gdata;
                stream_chan_o <= gidx;
                rr_q          <= rr_next;
            end else begin
                stream_v_o    <= 1'b0;
            end
        end
    end

    always @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(|(chan_yumi_i & ~chan_v_o)));
            assert (!status_alias_lp);
        end
    end

endmodule

// File: tb/tb_bp_stream_host_router.sv
// Randomised + directed bench for bp_stream_host_router against a queue-based
// behavioural model checked every cycle.
module tb_bp_stream_host_router;

    localparam int N  = 2;
    localparam int W  = 32;
    localparam int FE = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             stream_v_i;
    logic [31:0]      stream_addr_i;
    logic [W-1:0]     stream_data_i;
    logic             stream_yumi_o;
    logic [N-1:0]     chan_v_o;
    logic [N*W-1:0]   chan_data_o;
    logic [N-1:0]     chan_yumi_i;
    logic [N-1:0]     chan_v_i;
    logic [N*W-1:0]   chan_data_i;
    logic [N-1:0]     chan_ready_o;
    logic             stream_v_o;
    logic [W-1:0]     stream_data_o;
    logic [0:0]       stream_chan_o;
    logic             stream_ready_i;
    logic [15:0]      unmapped_cnt_o;

    always #5 clk = ~clk;

    bp_stream_host_router #(
        .num_chan_p(N), .stream_addr_width_p(32), .stream_data_width_p(W),
        .base_addr_p('h10), .addr_stride_p('h10), .status_addr_p('hF0),
        .fifo_els_p(FE)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .stream_v_i(stream_v_i), .stream_addr_i(stream_addr_i),
        .stream_data_i(stream_data_i), .stream_yumi_o(stream_yumi_o),
        .chan_v_o(chan_v_o), .chan_data_o(chan_data_o),
        .chan_yumi_i(chan_yumi_i), .chan_v_i(chan_v_i),
        .chan_data_i(chan_data_i), .chan_ready_o(chan_ready_o),
        .stream_v_o(stream_v_o), .stream_data_o(stream_data_o),
        .stream_chan_o(stream_chan_o), .stream_ready_i(stream_ready_i),
        .unmapped_cnt_o(unmapped_cnt_o)
    );

    logic [W-1:0] q [N][$];
    int           m_cnt  = 0;
    logic         m_v    = 1'b0;
    logic [W-1:0] m_data = '0;
    int           m_chan = 0;
    int           m_rr   = 0;
    int           n_cmp  = 0;
    int           n_bad  = 0;

    // -2: status register, -1: unmapped, else channel number
    function automatic int dec(input logic [31:0] a);
        longint off;
        if (a == 32'hF0) return -2;
        if (a < 32'h10) return -1;
        off = longint'(a) - 64'h10;
        if (off % 16 != 0) return -1;
        if (off / 16 >= N) return -1;
        return int'(off / 16);
    endfunction

    function automatic logic exp_yumi();
        int d;
        if (!rst_n || !stream_v_i) return 1'b0;
        d = dec(stream_addr_i);
        if (d < 0) return 1'b1;
        return q[d].size() < FE;
    endfunction

    function automatic int pick();
        int c;
        if (!rst_n || (m_v && !stream_ready_i)) return -1;
        for (int i = 0; i < N; i++) begin
            c = (m_rr + i) % N;
            if (chan_v_i[c]) return c;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin : model
        int   d;
        int   g;
        logic y;
        if (!rst_n) begin
            for (int k = 0; k < N; k++) q[k].delete();
            m_cnt  = 0;
            m_v    = 1'b0;
            m_data = '0;
            m_chan = 0;
            m_rr   = 0;
        end else begin
            y = exp_yumi();
            d = dec(stream_addr_i);
            g = pick();
            for (int k = 0; k < N; k++) begin
                if (chan_yumi_i[k] && q[k].size() > 0) void'(q[k].pop_front());
            end
            if (y && d >= 0) q[d].push_back(stream_data_i);
            if (y && d == -2) m_cnt = 0;
            else if (y && d == -1 && m_cnt < 65535) m_cnt++;
            if (g >= 0) begin
                m_v    = 1'b1;
                m_data = chan_data_i[g*W +: W];
                m_chan = g;
                m_rr   = (g + 1) % N;
            end else if (!m_v || stream_ready_i) begin
                m_v = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [N-1:0] er;
        int           g;
        chk("stream_yumi", stream_yumi_o, exp_yumi());
        for (int k = 0; k < N; k++) begin
            chk("chan_v", chan_v_o[k], q[k].size() != 0);
            if (q[k].size() != 0) chk("chan_data", chan_data_o[k*W +: W], q[k][0]);
        end
        g  = pick();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("chan_ready", chan_ready_o, er);
        chk("stream_v", stream_v_o, m_v);
        chk("stream_data", stream_data_o, m_data);
        chk("stream_chan", stream_chan_o, m_chan);
        chk("unmapped_cnt", unmapped_cnt_o, m_cnt);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stream_v_i     = 1'b0;
        stream_addr_i  = '0;
        stream_data_i  = '0;
        chan_yumi_i    = '0;
        chan_v_i       = '0;
        chan_data_i    = '0;
        stream_ready_i = 1'b0;
    endtask

    initial begin
        idle();
        // T1: reset with live inputs
        stream_v_i     = 1'b1;
        stream_addr_i  = 32'h10;
        chan_v_i       = '1;
        stream_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("t1_yumi", stream_yumi_o, 0);
        chk("t1_ready", chan_ready_o, 0);
        chk("t1_stream_v", stream_v_o, 0);
        chk("t1_chan_v", chan_v_o, 0);
        chk("t1_cnt", unmapped_cnt_o, 0);
        tick();
        idle();
        rst_n = 1'b1;
        tick();

        // T2: decode
        stream_v_i = 1'b1; stream_addr_i = 32'h10; stream_data_i = 32'hA;
        @(negedge clk);
        chk("t2_yumi_a", stream_yumi_o, 1);
        chk("t2_chan_v_pre", chan_v_o, 2'b00);
        tick();
        stream_addr_i = 32'h20; stream_data_i = 32'hB;
        @(negedge clk);
        chk("t2_chan_v0", chan_v_o, 2'b01);
        chk("t2_data0", chan_data_o[31:0], 32'hA);
        tick();
        stream_v_i = 1'b0;
        @(negedge clk);
        chk("t2_chan_v1", chan_v_o, 2'b11);
        chk("t2_data1", chan_data_o[63:32], 32'hB);
        tick();
        chan_yumi_i = chan_v_o;
        tick();
        chan_yumi_i = '0;

        // T3: full FIFO stalls the fifth beat
        for (int i = 1; i <= 4; i++) begin
            stream_v_i = 1'b1; stream_addr_i = 32'h10; stream_data_i = i;
            @(negedge clk);
            chk("t3_accept", stream_yumi_o, 1);
            tick();
        end
        stream_data_i = 5;
        @(negedge clk);
        chk("t3_stall", stream_yumi_o, 0);
        tick();
        @(negedge clk);
        chk("t3_stall", stream_yumi_o, 0);
        tick();
        chan_yumi_i = 2'b01;
        @(negedge clk);
        chk("t3_stall_deq", stream_yumi_o, 0);
        chk("t3_head1", chan_data_o[31:0], 1);
        tick();
        chan_yumi_i = 2'b00;
        @(negedge clk);
        chk("t3_accept5", stream_yumi_o, 1);
        tick();
        stream_v_i  = 1'b0;
        chan_yumi_i = 2'b01;
        for (int i = 2; i <= 5; i++) begin
            @(negedge clk);
            chk("t3_v", chan_v_o[0], 1);
            chk("t3_order", chan_data_o[31:0], i);
            tick();
        end
        chan_yumi_i = '0;

        // T4: unmapped counter, clear, saturation
        stream_v_i = 1'b1; stream_addr_i = 32'h44;
        repeat (3) begin
            @(negedge clk);
            chk("t4_yumi", stream_yumi_o, 1);
            tick();
        end
        stream_v_i = 1'b0;
        @(negedge clk);
        chk("t4_cnt3", unmapped_cnt_o, 3);
        tick();
        stream_v_i = 1'b1; stream_addr_i = 32'hF0;
        tick();
        stream_v_i = 1'b0;
        @(negedge clk);
        chk("t4_clear", unmapped_cnt_o, 0);
        tick();
        stream_v_i = 1'b1; stream_addr_i = 32'h44;
        repeat (65534) tick();
        stream_v_i = 1'b0;
        @(negedge clk);
        chk("t4_fffe", unmapped_cnt_o, 16'hFFFE);
        tick();
        stream_v_i = 1'b1;
        repeat (3) tick();
        stream_v_i = 1'b0;
        @(negedge clk);
        chk("t4_sat", unmapped_cnt_o, 16'hFFFF);
        tick();

        // T5: round-robin at full rate, then back-pressure
        chan_v_i = 2'b11; stream_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chan_data_i = {32'hB000 + 32'(i), 32'hA000 + 32'(i)};
            tick();
            chk("t5_v", stream_v_o, 1);
            chk("t5_chan", stream_chan_o, i % 2);
            chk("t5_data", stream_data_o,
                (i % 2 == 1) ? 32'hB000 + 32'(i) : 32'hA000 + 32'(i));
        end
        stream_ready_i = 1'b0;
        chan_data_i = {32'hB009, 32'hA009};
        repeat (3) begin
            tick();
            chk("t5_hold_v", stream_v_o, 1);
            chk("t5_hold_chan", stream_chan_o, 1);
            chk("t5_hold_data", stream_data_o, 32'hB005);
            chk("t5_hold_ready", chan_ready_o, 0);
        end
        stream_ready_i = 1'b1;
        tick();
        chk("t5_resume_chan", stream_chan_o, 0);
        chk("t5_resume_data", stream_data_o, 32'hA009);
        chan_v_i = '0;
        tick();
        chk("t5_drain", stream_v_o, 0);

        // T6: asynchronous reset mid-operation
        stream_ready_i = 1'b0;
        chan_v_i = 2'b01; chan_data_i = {32'h0, 32'hC1};
        stream_v_i = 1'b1; stream_addr_i = 32'h10; stream_data_i = 32'h61;
        tick();
        stream_data_i = 32'h62;
        tick();
        idle();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_chan_v", chan_v_o, 0);
        chk("t6_stream_v", stream_v_o, 0);
        chk("t6_data", stream_data_o, 0);
        chk("t6_chan", stream_chan_o, 0);
        chk("t6_cnt", unmapped_cnt_o, 0);
        tick();
        rst_n = 1'b1;
        repeat (4) begin
            tick();
            chk("t6_quiet_v", stream_v_o, 0);
            chk("t6_quiet_chan", chan_v_o, 0);
        end

        // randomised traffic
        for (int c = 0; c < 3000; c++) begin
            stream_v_i = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0, 1, 2: stream_addr_i = 32'h10;
                3, 4:    stream_addr_i = 32'h20;
                5:       stream_addr_i = 32'h30;
                6:       stream_addr_i = ($urandom_range(0, 3) == 0) ? 32'hF0 : 32'h44;
                default: stream_addr_i = $urandom();
            endcase
            stream_data_i = $urandom();
            for (int k = 0; k < N; k++) begin
                chan_yumi_i[k] = chan_v_o[k] && ($urandom_range(0, 2) == 0);
            end
            chan_v_i       = N'($urandom());
            chan_data_i    = {$urandom(), $urandom()};
            stream_ready_i = ($urandom_range(0, 3) != 0);
            tick();
        end
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
